// File: rtl/bch_pkg.sv
// Shared constants, types and state encoding for the BCH(15,7) t=2 encoder.
// Generator polynomial g(x) = x^8 + x^7 + x^6 + x^4 + 1.
package bch_pkg;

    localparam int N  = 15;
    localparam int K  = 7;
    localparam int NP = 8;

    // Full generator including the implicit x^8 term; the LFSR uses bits [7:0].
    localparam logic [NP:0] G = 9'h1D1;

    typedef logic [K-1:0]  msg_t;
    typedef logic [NP-1:0] par_t;
    typedef logic [N-1:0]  cw_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bch_lfsr_step.sv
// One bit of systematic polynomial division by g(x): folds the next message
// bit into the running remainder held in the parity LFSR.
module bch_lfsr_step
    import bch_pkg::*;
(
    input  logic [NP-1:0] lfsr_i,
    input  logic          din_i,
    output logic [NP-1:0] lfsr_o
);

    logic fb;

    // Feedback is the outgoing remainder bit combined with the incoming message bit.
    always_comb begin
        fb     = lfsr_i[NP-1] ^ din_i;
        lfsr_o = {lfsr_i[NP-2:0], 1'b0} ^ (fb ? G[NP-1:0] : '0);
    end

endmodule

// File: rtl/bch_encoder.sv
// BCH(15,7) systematic encoder: accepts a 7-bit message, shifts it through the
// division LFSR for 7 cycles and presents {msg, parity} until the sink takes it.
// Optional build macro BCH_ENC_ERR_INJECT_EN adds an err_mask input whose value,
// captured with the message, is XORed onto the codeword (decoder test stimulus).
module bch_encoder
    import bch_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [K-1:0]  msg,
`ifdef BCH_ENC_ERR_INJECT_EN
    input  logic [N-1:0]  err_mask,
`endif
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  cw,
    output logic          busy
);

    state_t        state_q, state_d;
    msg_t          msg_q,   msg_d;
    msg_t          shift_q, shift_d;
    par_t          lfsr_q,  lfsr_d;
    logic [2:0]    cnt_q,   cnt_d;
    par_t          lfsr_next;
`ifdef BCH_ENC_ERR_INJECT_EN
    cw_t           err_q,   err_d;
`endif

    bch_lfsr_step u_step (
        .lfsr_i (lfsr_q),
        .din_i  (shift_q[K-1]),
        .lfsr_o (lfsr_next)
    );

    // Next-state and datapath updates for IDLE -> CALC -> DONE -> IDLE.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        msg_d   = msg_q;
        shift_d = shift_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
`ifdef BCH_ENC_ERR_INJECT_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = CALC;
                    msg_d   = msg;
                    shift_d = msg;
                    lfsr_d  = '0;
                    cnt_d   = 3'd6;
`ifdef BCH_ENC_ERR_INJECT_EN
                    err_d   = err_mask;
`endif
                end
            end
            CALC: begin
                lfsr_d  = lfsr_next;
                shift_d = {shift_q[K-2:0], 1'b0};
                if (cnt_q == 3'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; all cleared by reset so cw reads 0 afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            msg_q   <= '0;
            shift_q <= '0;
            lfsr_q  <= '0;
            cnt_q   <= '0;
`ifdef BCH_ENC_ERR_INJECT_EN
            err_q   <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            msg_q   <= msg_d;
            shift_q <= shift_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
`ifdef BCH_ENC_ERR_INJECT_EN
            err_q   <= err_d;
`endif
        end
    end

    // Outputs come straight from registers; cw only changes on accept or in CALC.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
`ifdef BCH_ENC_ERR_INJECT_EN
        cw        = {msg_q, lfsr_q} ^ err_q;
`else
        cw        = {msg_q, lfsr_q};
`endif
    end

endmodule
